// File: rtl/cp0_pkg.sv
// Shared CP0 TLB definitions: register numbers, TLB op encodings, field positions
// and the per-register MTC0 write masks.
package cp0_pkg;

    localparam int TLB_IDX_W = 4;

    typedef enum logic [4:0] {
        CP0_INDEX    = 5'd0,
        CP0_RANDOM   = 5'd1,
        CP0_ENTRYLO0 = 5'd2,
        CP0_ENTRYLO1 = 5'd3,
        CP0_CONTEXT  = 5'd4,
        CP0_WIRED    = 5'd6,
        CP0_BADVADDR = 5'd8,
        CP0_ENTRYHI  = 5'd10
    } cp0_reg_e;

    typedef enum logic [3:0] {
        TLB_OP_NONE = 4'b0000,
        TLB_OP_P    = 4'b0001,
        TLB_OP_R    = 4'b0010,
        TLB_OP_WI   = 4'b0100,
        TLB_OP_WR   = 4'b1000
    } tlb_op_e;

    localparam int INDEX_P_BIT         = 31;
    localparam int ENTRYHI_VPN2_LSB    = 13;
    localparam int ENTRYLO_PFN_LSB     = 6;
    localparam int CONTEXT_PTEBASE_LSB = 23;
    localparam int CONTEXT_BADVPN2_LSB = 4;

    // Bits that exist in each writable register; everything else reads 0.
    localparam logic [31:0] INDEX_WMASK   = 32'h8000_000F;
    localparam logic [31:0] ENTRYLO_WMASK = 32'h03FF_FFC7;
    localparam logic [31:0] CONTEXT_WMASK = 32'hFFFF_FFF0;
    localparam logic [31:0] WIRED_WMASK   = 32'h0000_000F;
    localparam logic [31:0] ENTRYHI_WMASK = 32'hFFFF_E0FF;

endpackage

// File: rtl/cp0_random.sv
// Random replacement counter: counts down from TOP to Wired and wraps, frozen on
// stall, forced back to TOP whenever Wired is written.
module cp0_random
    import cp0_pkg::*;
#(
    parameter logic [TLB_IDX_W-1:0] TOP = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 wired_we_i,
    input  logic [TLB_IDX_W-1:0] wired_i,
    output logic [TLB_IDX_W-1:0] random_o
);

    logic [TLB_IDX_W-1:0] random_q;
    logic [TLB_IDX_W-1:0] random_d;

    always_comb begin
        random_d = random_q;
        if (wired_we_i) begin
            random_d = TOP;
        end else if (!stall_i) begin
            random_d = (random_q <= wired_i) ? TOP : random_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            random_q <= TOP;
        end else begin
            random_q <= random_d;
        end
    end

    assign random_o = random_q;

endmodule

// File: rtl/cp0_tlb_regs.sv
// CP0 TLB register file sitting in front of TLB_16: MTC0/MFC0 access, TLBP/TLBR
// result capture one cycle after issue, and TLB exception address latching.
module cp0_tlb_regs
    import cp0_pkg::*;
#(
    parameter int TLB_ENTRIES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 mtc0_we,
    input  logic [4:0]           cp0_waddr,
    input  logic [4:0]           cp0_raddr,
    input  logic [31:0]          cp0_wdata,
    output logic [31:0]          cp0_rdata,
    input  logic [3:0]           tlb_op_in,
    input  logic                 exc_tlb,
    input  logic [31:0]          exc_vaddr,
    output logic [3:0]           op,
    output logic [31:0]          INDEX,
    output logic [31:0]          RANDOM,
    output logic [31:0]          ENTRY_HI,
    output logic [31:0]          ENTRY_LO0,
    output logic [31:0]          ENTRY_LO1,
    input  logic                 INDEX_P,
    input  logic [TLB_IDX_W-1:0] INDEX_INDEX,
    input  logic [18:0]          ENTRY_HI_VPN2,
    input  logic [7:0]           ENTRY_HI_ASID,
    input  logic [19:0]          ENTRY_LO0_PFN,
    input  logic [1:0]           ENTRY_LO0_DV,
    input  logic [19:0]          ENTRY_LO1_PFN,
    input  logic [1:0]           ENTRY_LO1_DV,
    input  logic                 ENTRY_LO_G,
    output logic                 busy
);

    logic [31:0] index_q, index_d;
    logic [31:0] entrylo0_q, entrylo0_d;
    logic [31:0] entrylo1_q, entrylo1_d;
    logic [31:0] context_q, context_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] entryhi_q, entryhi_d;
    logic [TLB_IDX_W-1:0] wired_q, wired_d;
    logic pend_p_q, pend_p_d;
    logic pend_r_q, pend_r_d;
    logic [3:0] issue;
    logic wired_we;
    logic [TLB_IDX_W-1:0] random_val;

    assign wired_we = mtc0_we && (cp0_waddr == CP0_WIRED);
    assign issue    = stall ? TLB_OP_NONE : tlb_op_in;

    cp0_random #(
        .TOP(TLB_IDX_W'(TLB_ENTRIES - 1))
    ) u_random (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .wired_we_i (wired_we),
        .wired_i    (wired_q),
        .random_o   (random_val)
    );

    // Later assignments win: exception over TLBP/TLBR capture over MTC0.
    always_comb begin
        index_d    = index_q;
        entrylo0_d = entrylo0_q;
        entrylo1_d = entrylo1_q;
        context_d  = context_q;
        badvaddr_d = badvaddr_q;
        entryhi_d  = entryhi_q;
        wired_d    = wired_q;

        if (mtc0_we) begin
            case (cp0_waddr)
                CP0_INDEX:    index_d    = cp0_wdata & INDEX_WMASK;
                CP0_ENTRYLO0: entrylo0_d = cp0_wdata & ENTRYLO_WMASK;
                CP0_ENTRYLO1: entrylo1_d = cp0_wdata & ENTRYLO_WMASK;
                CP0_CONTEXT:  context_d  = cp0_wdata & CONTEXT_WMASK;
                CP0_WIRED:    wired_d    = cp0_wdata[TLB_IDX_W-1:0];
                CP0_ENTRYHI:  entryhi_d  = cp0_wdata & ENTRYHI_WMASK;
                default: ;
            endcase
        end

        if (!exc_tlb && pend_p_q) begin
            index_d                  = '0;
            index_d[INDEX_P_BIT]     = INDEX_P;
            index_d[TLB_IDX_W-1:0]   = INDEX_INDEX;
        end

        if (!exc_tlb && pend_r_q) begin
            entryhi_d = {ENTRY_HI_VPN2, 5'b0, ENTRY_HI_ASID};
            entrylo0_d = '0;
            entrylo0_d[ENTRYLO_PFN_LSB +: 20] = ENTRY_LO0_PFN;
            entrylo0_d[2:0] = {ENTRY_LO0_DV, ENTRY_LO_G};
            entrylo1_d = '0;
            entrylo1_d[ENTRYLO_PFN_LSB +: 20] = ENTRY_LO1_PFN;
            entrylo1_d[2:0] = {ENTRY_LO1_DV, ENTRY_LO_G};
        end

        if (exc_tlb) begin
            badvaddr_d = exc_vaddr;
            entryhi_d  = {exc_vaddr[31:ENTRYHI_VPN2_LSB], entryhi_q[ENTRYHI_VPN2_LSB-1:0]};
            context_d  = {context_q[31:CONTEXT_PTEBASE_LSB], exc_vaddr[31:ENTRYHI_VPN2_LSB],
                          context_q[CONTEXT_BADVPN2_LSB-1:0]};
        end

        pend_p_d = !exc_tlb && (issue == TLB_OP_P);
        pend_r_d = !exc_tlb && (issue == TLB_OP_R);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index_q    <= '0;
            entrylo0_q <= '0;
            entrylo1_q <= '0;
            context_q  <= '0;
            badvaddr_q <= '0;
            entryhi_q  <= '0;
            wired_q    <= '0;
            pend_p_q   <= 1'b0;
            pend_r_q   <= 1'b0;
        end else begin
            index_q    <= index_d;
            entrylo0_q <= entrylo0_d;
            entrylo1_q <= entrylo1_d;
            context_q  <= context_d;
            badvaddr_q <= badvaddr_d;
            entryhi_q  <= entryhi_d;
            wired_q    <= wired_d;
            pend_p_q   <= pend_p_d;
            pend_r_q   <= pend_r_d;
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            CP0_INDEX:    cp0_rdata = index_q;
            CP0_RANDOM:   cp0_rdata = RANDOM;
            CP0_ENTRYLO0: cp0_rdata = entrylo0_q;
            CP0_ENTRYLO1: cp0_rdata = entrylo1_q;
            CP0_CONTEXT:  cp0_rdata = context_q;
            CP0_WIRED:    cp0_rdata = {{(32-TLB_IDX_W){1'b0}}, wired_q};
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_ENTRYHI:  cp0_rdata = entryhi_q;
            default:      cp0_rdata = '0;
        endcase
    end

    assign op        = issue;
    assign INDEX     = index_q;
    assign RANDOM    = {{(32-TLB_IDX_W){1'b0}}, random_val};
    assign ENTRY_HI  = entryhi_q;
    assign ENTRY_LO0 = entrylo0_q;
    assign ENTRY_LO1 = entrylo1_q;
    assign busy      = pend_p_q | pend_r_q;

endmodule

// File: tb/tb_cp0_tlb_regs.sv
// Bench for cp0_tlb_regs: directed scenarios followed by randomized traffic,
// all checked against a register-array reference model.
module tb_cp0_tlb_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        mtc0_we;
    logic [4:0]  cp0_waddr;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [3:0]  tlb_op_in;
    logic        exc_tlb;
    logic [31:0] exc_vaddr;
    logic [3:0]  op;
    logic [31:0] INDEX, RANDOM, ENTRY_HI, ENTRY_LO0, ENTRY_LO1;
    logic        INDEX_P;
    logic [3:0]  INDEX_INDEX;
    logic [18:0] ENTRY_HI_VPN2;
    logic [7:0]  ENTRY_HI_ASID;
    logic [19:0] ENTRY_LO0_PFN;
    logic [1:0]  ENTRY_LO0_DV;
    logic [19:0] ENTRY_LO1_PFN;
    logic [1:0]  ENTRY_LO1_DV;
    logic        ENTRY_LO_G;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_reg [32];
    logic        m_pend_p, m_pend_r;

    always #5 clk = ~clk;

    cp0_tlb_regs #(.TLB_ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .mtc0_we(mtc0_we),
        .cp0_waddr(cp0_waddr), .cp0_raddr(cp0_raddr), .cp0_wdata(cp0_wdata),
        .cp0_rdata(cp0_rdata), .tlb_op_in(tlb_op_in), .exc_tlb(exc_tlb),
        .exc_vaddr(exc_vaddr), .op(op), .INDEX(INDEX), .RANDOM(RANDOM),
        .ENTRY_HI(ENTRY_HI), .ENTRY_LO0(ENTRY_LO0), .ENTRY_LO1(ENTRY_LO1),
        .INDEX_P(INDEX_P), .INDEX_INDEX(INDEX_INDEX), .ENTRY_HI_VPN2(ENTRY_HI_VPN2),
        .ENTRY_HI_ASID(ENTRY_HI_ASID), .ENTRY_LO0_PFN(ENTRY_LO0_PFN),
        .ENTRY_LO0_DV(ENTRY_LO0_DV), .ENTRY_LO1_PFN(ENTRY_LO1_PFN),
        .ENTRY_LO1_DV(ENTRY_LO1_DV), .ENTRY_LO_G(ENTRY_LO_G), .busy(busy)
    );

    // Writable bits per register number; zero means MTC0 has no effect.
    function automatic logic [31:0] wmask(int a);
        case (a)
            0:       return 32'h8000_000F;
            2, 3:    return 32'h03FF_FFC7;
            4:       return 32'hFFFF_FFF0;
            6:       return 32'h0000_000F;
            10:      return 32'hFFFF_E0FF;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_reg[1] = 32'd15;
        m_pend_p = 1'b0;
        m_pend_r = 1'b0;
    endtask

    // Register state after the coming rising edge, from the current inputs.
    task automatic model_edge();
        logic [31:0] n [32];
        logic [3:0]  issue;
        int          wa;
        n  = m_reg;
        wa = int'(cp0_waddr);
        if (mtc0_we && wmask(wa) != 0) n[wa] = cp0_wdata & wmask(wa);
        if (mtc0_we && wa == 6) n[1] = 32'd15;
        else if (!stall) n[1] = (m_reg[1] <= m_reg[6]) ? 32'd15 : m_reg[1] - 32'd1;
        if (!exc_tlb && m_pend_p) n[0] = (INDEX_P ? 32'h8000_0000 : 32'h0) + 32'(INDEX_INDEX);
        if (!exc_tlb && m_pend_r) begin
            n[10] = 32'(ENTRY_HI_VPN2) * 8192 + 32'(ENTRY_HI_ASID);
            n[2]  = 32'(ENTRY_LO0_PFN) * 64 + 32'(ENTRY_LO0_DV) * 2 + 32'(ENTRY_LO_G);
            n[3]  = 32'(ENTRY_LO1_PFN) * 64 + 32'(ENTRY_LO1_DV) * 2 + 32'(ENTRY_LO_G);
        end
        if (exc_tlb) begin
            n[8]  = exc_vaddr;
            n[10] = (exc_vaddr & 32'hFFFF_E000) | (m_reg[10] & 32'h0000_00FF);
            n[4]  = (m_reg[4] & 32'hFF80_0000) | ((exc_vaddr >> 13) << 4);
        end
        issue    = stall ? 4'b0 : tlb_op_in;
        m_pend_p = !exc_tlb && issue == 4'b0001;
        m_pend_r = !exc_tlb && issue == 4'b0010;
        m_reg    = n;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; mtc0_we = 0; cp0_waddr = 0; cp0_raddr = 0; cp0_wdata = 0;
        tlb_op_in = 0; exc_tlb = 0; exc_vaddr = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1; cp0_waddr = a; cp0_wdata = d;
        tick();
        mtc0_we = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        INDEX_P = 0; INDEX_INDEX = 0; ENTRY_HI_VPN2 = 0; ENTRY_HI_ASID = 0;
        ENTRY_LO0_PFN = 0; ENTRY_LO0_DV = 0; ENTRY_LO1_PFN = 0; ENTRY_LO1_DV = 0; ENTRY_LO_G = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cp0_raddr = 5'd1;
        #1;
        vectors++;
        if (cp0_rdata !== 32'd15) begin miscompares++; $display("FAIL reset_random: got %h want %h", cp0_rdata, 32'd15); end
        vectors++;
        if (op !== 4'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_op_busy: got op=%b busy=%b want 0/0", op, busy); end
        vectors++;
        if (INDEX !== 0 || ENTRY_HI !== 0 || ENTRY_LO0 !== 0 || ENTRY_LO1 !== 0 || RANDOM !== 32'd15) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h %h %h %h %h want 0 0 0 0 f", INDEX, ENTRY_HI, ENTRY_LO0, ENTRY_LO1, RANDOM);
        end
        rst = 1;
    endtask

    task automatic test_random_walk();
        cp0_raddr = 5'd1;
        repeat (3) tick();
        vectors++;
        if (cp0_rdata !== 32'd12) begin miscompares++; $display("FAIL random_after3: got %h want %h", cp0_rdata, 32'd12); end
        stall = 1;
        repeat (2) tick();
        stall = 0;
        vectors++;
        if (cp0_rdata !== 32'd12) begin miscompares++; $display("FAIL random_stall_freeze: got %h want %h", cp0_rdata, 32'd12); end
        repeat (12) tick();
        vectors++;
        if (cp0_rdata !== 32'd0) begin miscompares++; $display("FAIL random_at_wired0: got %h want %h", cp0_rdata, 32'd0); end
        tick();
        vectors++;
        if (cp0_rdata !== 32'd15) begin miscompares++; $display("FAIL random_wrap: got %h want %h", cp0_rdata, 32'd15); end
    endtask

    task automatic test_wired();
        repeat (4) tick();
        mtc0(5'd6, 32'hFFFF_FFF3);
        cp0_raddr = 5'd1;
        #1;
        vectors++;
        if (cp0_rdata !== 32'd15) begin miscompares++; $display("FAIL wired_resets_random: got %h want %h", cp0_rdata, 32'd15); end
        cp0_raddr = 5'd6;
        #1;
        vectors++;
        if (cp0_rdata !== 32'd3) begin miscompares++; $display("FAIL wired_read: got %h want %h", cp0_rdata, 32'd3); end
        cp0_raddr = 5'd1;
        repeat (12) tick();
        vectors++;
        if (cp0_rdata !== 32'd3) begin miscompares++; $display("FAIL random_at_wired3: got %h want %h", cp0_rdata, 32'd3); end
        tick();
        vectors++;
        if (cp0_rdata !== 32'd15) begin miscompares++; $display("FAIL random_wrap_wired3: got %h want %h", cp0_rdata, 32'd15); end
        mtc0(5'd1, 32'd5);
        vectors++;
        if (cp0_rdata !== 32'd14) begin miscompares++; $display("FAIL random_readonly: got %h want %h", cp0_rdata, 32'd14); end
    endtask

    task automatic test_tlbwi();
        mtc0(5'd10, 32'h0000_4000);
        mtc0(5'd2, 32'h03FF_FFC2);
        mtc0(5'd0, 32'h0);
        tlb_op_in = 4'b0100;
        #1;
        vectors++;
        if (op !== 4'b0100) begin miscompares++; $display("FAIL tlbwi_op: got %b want %b", op, 4'b0100); end
        tick();
        tlb_op_in = 4'b0;
        #1;
        vectors++;
        if (op !== 4'b0) begin miscompares++; $display("FAIL tlbwi_op_one_cycle: got %b want %b", op, 4'b0); end
        vectors++;
        if (ENTRY_LO0 !== 32'h03FF_FFC2 || INDEX !== 32'h0 || ENTRY_HI !== 32'h0000_4000) begin
            miscompares++;
            $display("FAIL tlbwi_outputs: got lo0=%h idx=%h hi=%h want 03ffffc2 0 4000", ENTRY_LO0, INDEX, ENTRY_HI);
        end
        stall = 1; tlb_op_in = 4'b1000;
        #1;
        vectors++;
        if (op !== 4'b0) begin miscompares++; $display("FAIL stall_blocks_op: got %b want %b", op, 4'b0); end
        stall = 0; tlb_op_in = 4'b0;
    endtask

    task automatic test_tlbp();
        INDEX_P = 0; INDEX_INDEX = 4'd1;
        tlb_op_in = 4'b0001;
        tick();
        tlb_op_in = 0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL tlbp_busy: got %b want 1", busy); end
        cp0_raddr = 5'd0;
        tick();
        vectors++;
        if (busy !== 1'b0 || cp0_rdata !== 32'h0000_0001) begin
            miscompares++; $display("FAIL tlbp_p0: got busy=%b idx=%h want 0 00000001", busy, cp0_rdata);
        end
        INDEX_P = 1;
        tlb_op_in = 4'b0001;
        tick();
        tlb_op_in = 0;
        stall = 1;
        tick();
        stall = 0;
        vectors++;
        if (cp0_rdata !== 32'h8000_0001) begin miscompares++; $display("FAIL tlbp_p1_stalled: got %h want %h", cp0_rdata, 32'h8000_0001); end
    endtask

    task automatic test_tlbr();
        ENTRY_HI_VPN2 = 19'd1; ENTRY_HI_ASID = 8'hFF;
        ENTRY_LO0_PFN = 20'hFFFFD; ENTRY_LO0_DV = 2'b11;
        ENTRY_LO1_PFN = 20'h12345; ENTRY_LO1_DV = 2'b01; ENTRY_LO_G = 1;
        tlb_op_in = 4'b0010;
        tick();
        tlb_op_in = 0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL tlbr_busy: got %b want 1", busy); end
        tick();
        cp0_raddr = 5'd10;
        #1;
        vectors++;
        if (cp0_rdata !== 32'h0000_20FF) begin miscompares++; $display("FAIL tlbr_entryhi: got %h want %h", cp0_rdata, 32'h0000_20FF); end
        cp0_raddr = 5'd2;
        #1;
        vectors++;
        if (cp0_rdata !== 32'h03FF_FF47) begin miscompares++; $display("FAIL tlbr_entrylo0: got %h want %h", cp0_rdata, 32'h03FF_FF47); end
        vectors++;
        if (ENTRY_LO1 !== 32'h0048_D143) begin miscompares++; $display("FAIL tlbr_entrylo1: got %h want %h", ENTRY_LO1, 32'h0048_D143); end
    endtask

    task automatic test_exc();
        INDEX_P = 0; INDEX_INDEX = 4'd7;
        tlb_op_in = 4'b0001;
        tick();
        tlb_op_in = 0;
        exc_tlb = 1; exc_vaddr = 32'h0000_4004;
        tick();
        exc_tlb = 0;
        cp0_raddr = 5'd8;
        #1;
        vectors++;
        if (cp0_rdata !== 32'h0000_4004) begin miscompares++; $display("FAIL exc_badvaddr: got %h want %h", cp0_rdata, 32'h0000_4004); end
        vectors++;
        if (ENTRY_HI !== 32'h0000_40FF) begin miscompares++; $display("FAIL exc_entryhi: got %h want %h", ENTRY_HI, 32'h0000_40FF); end
        cp0_raddr = 5'd4;
        #1;
        vectors++;
        if (cp0_rdata !== 32'h0000_0020) begin miscompares++; $display("FAIL exc_context: got %h want %h", cp0_rdata, 32'h0000_0020); end
        vectors++;
        if (INDEX !== 32'h8000_0001 || busy !== 1'b0) begin
            miscompares++; $display("FAIL exc_drops_tlbp: got idx=%h busy=%b want 80000001 0", INDEX, busy);
        end
    endtask

    task automatic test_reset_abort();
        ENTRY_HI_VPN2 = 19'h7_0000; ENTRY_HI_ASID = 8'h12;
        tlb_op_in = 4'b0010;
        tick();
        tlb_op_in = 0;
        rst = 0;
        #1;
        vectors++;
        if (busy !== 1'b0 || ENTRY_HI !== 32'h0 || RANDOM !== 32'd15) begin
            miscompares++; $display("FAIL reset_abort: got busy=%b hi=%h rnd=%h want 0 0 f", busy, ENTRY_HI, RANDOM);
        end
        @(posedge clk);
        #1;
        model_reset();
        rst = 1;
        #1;
        vectors++;
        if (ENTRY_HI !== 32'h0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_abort_no_capture: got hi=%h busy=%b want 0 0", ENTRY_HI, busy);
        end
    endtask

    task automatic test_random_traffic();
        logic [3:0] ops [7] = '{4'b0, 4'b0, 4'b0, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [3:0] exp_op;
        for (int c = 0; c < 600; c++) begin
            stall     = ($urandom_range(0, 3) == 0);
            mtc0_we   = ($urandom_range(0, 2) == 0);
            cp0_waddr = 5'($urandom_range(0, 11));
            cp0_wdata = $urandom;
            if (cp0_waddr == 5'd6 && $urandom_range(0, 1) == 0) cp0_wdata = 32'($urandom_range(0, 4));
            cp0_raddr = 5'($urandom_range(0, 31));
            tlb_op_in = ops[$urandom_range(0, 6)];
            exc_tlb   = ($urandom_range(0, 9) == 0);
            exc_vaddr = $urandom;
            INDEX_P = 1'($urandom); INDEX_INDEX = 4'($urandom);
            ENTRY_HI_VPN2 = 19'($urandom); ENTRY_HI_ASID = 8'($urandom);
            ENTRY_LO0_PFN = 20'($urandom); ENTRY_LO0_DV = 2'($urandom);
            ENTRY_LO1_PFN = 20'($urandom); ENTRY_LO1_DV = 2'($urandom);
            ENTRY_LO_G = 1'($urandom);
            #1;
            exp_op = stall ? 4'b0 : tlb_op_in;
            vectors++;
            if (cp0_rdata !== m_reg[cp0_raddr]) begin
                miscompares++; $display("FAIL rand_rdata[%0d] reg %0d: got %h want %h", c, cp0_raddr, cp0_rdata, m_reg[cp0_raddr]);
            end
            vectors++;
            if (op !== exp_op || busy !== (m_pend_p | m_pend_r)) begin
                miscompares++; $display("FAIL rand_op_busy[%0d]: got %b/%b want %b/%b", c, op, busy, exp_op, m_pend_p | m_pend_r);
            end
            vectors++;
            if (INDEX !== m_reg[0] || RANDOM !== m_reg[1] || ENTRY_HI !== m_reg[10] ||
                ENTRY_LO0 !== m_reg[2] || ENTRY_LO1 !== m_reg[3]) begin
                miscompares++;
                $display("FAIL rand_tlb_out[%0d]: got %h %h %h %h %h want %h %h %h %h %h", c,
                         INDEX, RANDOM, ENTRY_HI, ENTRY_LO0, ENTRY_LO1,
                         m_reg[0], m_reg[1], m_reg[10], m_reg[2], m_reg[3]);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_random_walk();
        test_wired();
        test_tlbwi();
        test_tlbp();
        test_tlbr();
        test_exc();
        test_reset_abort();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cp0_tlb_regs.md
# cp0_tlb_regs

CP0 TLB register file for the pipelined MIPS CPU: holds Index, Random, EntryLo0/1, Context, Wired, BadVAddr and EntryHi, and drives the op/INDEX/RANDOM/ENTRY_* inputs of `TLB_16`. It sits directly upstream of `TLB_16` and also consumes its TLBP/TLBR result fields and its ITLB/DTLB exception flags. It serves MTC0/MFC0 and TLBP/TLBR/TLBWI/TLBWR issued from the MEM stage.

## Interface
- `TLB_ENTRIES`, 16: TLB size; index width is log2 = 4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low (`rst`=0 resets).
- `stall`  in  1  pipeline stall; freezes Random and blocks op issue.
- `mtc0_we`  in  1  MTC0 write strobe.
- `cp0_waddr` / `cp0_raddr`  in  5  CP0 register number.
- `cp0_wdata`  in  32  MTC0 data.
- `cp0_rdata`  out  32  MFC0 data, combinational from `cp0_raddr`.
- `tlb_op_in`  in  4  one-hot: 0001 TLBP, 0010 TLBR, 0100 TLBWI, 1000 TLBWR.
- `exc_tlb`  in  1  TLB exception (refill/invalid/modified, I or D) taken this cycle.
- `exc_vaddr`  in  32  faulting virtual address.
- `op`  out  4  to TLB.
- `INDEX`, `RANDOM`, `ENTRY_HI`, `ENTRY_LO0`, `ENTRY_LO1`  out  32  to TLB.
- `INDEX_P` 1, `INDEX_INDEX` 4, `ENTRY_HI_VPN2` 19, `ENTRY_HI_ASID` 8, `ENTRY_LO0_PFN` 20, `ENTRY_LO0_DV` 2, `ENTRY_LO1_PFN` 20, `ENTRY_LO1_DV` 2, `ENTRY_LO_G` 1  in  from TLB.
- `busy`  out  1  high in the cycle after a TLBP/TLBR issue (result capture); the hazard unit must stall dependent MFC0.

## Operation
- Register numbers: Index 0, Random 1, EntryLo0 2, EntryLo1 3, Context 4, Wired 6, BadVAddr 8, EntryHi 10. Unimplemented registers read 0, and writes to them are ignored.
- Field layout:
  - Index: P[31], idx[3:0].
  - EntryHi: VPN2[31:13], ASID[7:0].
  - EntryLo: PFN[25:6], D[2], V[1], G[0].
  - Context: PTEBase[31:23], BadVPN2[22:4].
  - Wired: [3:0].
  - All other bits read 0.
- Read-only registers:
  - Random: MTC0 is ignored.
  - BadVAddr: MTC0 is ignored.
- Wired write: any MTC0 to Wired also sets Random to 15.
- `op` = `tlb_op_in` when `stall`=0, else 0. `INDEX`, `RANDOM`, `ENTRY_*` always present the current register values.
- TLBWI / TLBWR: no local state change. The TLB writes at the same edge using `INDEX` or `RANDOM`.
- TLBP / TLBR: set `pend_p` or `pend_r`. At the next edge:
  - TLBP: Index ← {INDEX_P, 27'b0, INDEX_INDEX}.
  - TLBR: EntryHi ← {VPN2, 5'b0, ASID}. EntryLo0/1 ← {6'b0, PFN, 3'b0, DV, G}.
  - Both pending flags clear.
- Random:
  - Reset value 15.
  - Each edge with `stall`=0: if Random ≤ Wired, Random ← 15; otherwise Random ← Random−1.
  - Result: Random cycles 15 → Wired.
- TLB exception (`exc_tlb`=1): at the edge:
  - BadVAddr ← exc_vaddr.
  - EntryHi.VPN2 ← exc_vaddr[31:13]; ASID unchanged.
  - Context.BadVPN2 ← exc_vaddr[31:13].
  - Any pending TLBP/TLBR is dropped.
- Priority per register at one edge: exception > pending TLBP/TLBR capture > MTC0.

## Timing
- Reset (async, `rst`=0): all registers 0 except Random = 15; pending flags 0. Consequently `op`=0, `busy`=0, and all 32-bit outputs 0 except `RANDOM`=15.
- MTC0: written value is visible on `cp0_rdata` and the TLB outputs the cycle after the edge. There is no MFC0 bypass within the same cycle.
- TLBP/TLBR: issued at cycle N. `busy`=1 during cycle N+1. Captured value is readable from cycle N+2.
- `stall` during a pending cycle does not block the capture.
- `rst` asserted mid-operation aborts the capture immediately.

## Structure
- Package `cp0_pkg`:
  - CP0 register numbers.
  - TLB op one-hot encodings.
  - Field bit positions.
  - `TLB_IDX_W` = 4.
- One sub-module, `cp0_random`: the Random counter with its Wired bound, stall freeze and reset-on-Wired-write.

## Test plan
- Reset, then MFC0 Random → 15. Run 3 unstalled cycles with Wired=0 → 12. Run 13 further cycles → wraps to 15.
- MTC0 Wired=3 → Random=15 next cycle. After 13 cycles it reads 3, then 15.
- MTC0 EntryHi=0x0000_4000, EntryLo0=0x03FF_FFC2, Index=0, then issue TLBWI → `op`=0100 for one cycle. `ENTRY_LO0`=0x03FF_FFC2, `INDEX`=0.
- TLBP with the TLB returning P=0, idx=1 → `busy`=1 for one cycle, then Index reads 0x0000_0001. With P=1 it reads 0x8000_0001.
- TLBR with VPN2=1, ASID=0xFF, PFN0=0xFFFFD, DV0=11, G=1 → EntryHi=0x0000_20FF, EntryLo0=0x03FF_FF47.
- `exc_tlb` with vaddr=0x0000_4004, asserted in the same cycle as a pending TLBP capture → BadVAddr=0x0000_4004, EntryHi=0x0000_4000|ASID, Context=0x0000_0020. Index is unchanged.
